riscv_simd_mac_unit: RTL and testbench



---
 rtl/riscv_simd_mac_unit_pkg.sv | 41 ++++
 rtl/riscv_simd_dot.sv | 58 +++++
 rtl/riscv_simd_mac_unit.sv | 133 +++++++++++++
 tb/tb_riscv_simd_mac_unit.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_simd_mac_unit_pkg.sv
// Opcode encodings and FSM state type shared by the SIMD MAC unit and its datapath.
// SMAC opcodes sit above the legacy MAC/convolution opcodes in the same operator field.
package riscv_simd_mac_unit_pkg;

    localparam int unsigned MAC_OP_WIDTH = 4;

    localparam logic [MAC_OP_WIDTH-1:0] MAC_OP     = 4'h0;
    localparam logic [MAC_OP_WIDTH-1:0] CON_2X2_OP = 4'h1;
    localparam logic [MAC_OP_WIDTH-1:0] CON_OP     = 4'h2;
    localparam logic [MAC_OP_WIDTH-1:0] WB23_OP    = 4'h3;
    localparam logic [MAC_OP_WIDTH-1:0] SMAC_DOTU  = 4'h4;
    localparam logic [MAC_OP_WIDTH-1:0] SMAC_DOTS  = 4'h5;
    localparam logic [MAC_OP_WIDTH-1:0] SMAC_ACCU  = 4'h6;
    localparam logic [MAC_OP_WIDTH-1:0] SMAC_ACCS  = 4'h7;
    localparam logic [MAC_OP_WIDTH-1:0] SMAC_CLR   = 4'h8;
    localparam logic [MAC_OP_WIDTH-1:0] SMAC_RD    = 4'h9;

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        SUM,
        FINISH
    } smac_state_e;

    function automatic logic smac_is_dot_acc(input logic [MAC_OP_WIDTH-1:0] op);
        return (op == SMAC_DOTU) || (op == SMAC_DOTS) || (op == SMAC_ACCU) || (op == SMAC_ACCS);
    endfunction

    function automatic logic smac_is_ctl(input logic [MAC_OP_WIDTH-1:0] op);
        return (op == SMAC_CLR) || (op == SMAC_RD);
    endfunction

    function automatic logic smac_is_signed(input logic [MAC_OP_WIDTH-1:0] op);
        return (op == SMAC_DOTS) || (op == SMAC_ACCS);
    endfunction

    function automatic logic smac_is_acc(input logic [MAC_OP_WIDTH-1:0] op);
        return (op == SMAC_ACCU) || (op == SMAC_ACCS);
    endfunction

endpackage

// File: rtl/riscv_simd_dot.sv
// Packed-SIMD dot-product datapath: lane multipliers, registered products and the
// reduction that sums them into an ACC_W-wide (zero- or sign-extended) dot value.
module riscv_simd_dot #(
    parameter int unsigned ELEM_W = 8,
    parameter int unsigned ACC_W  = 40
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mult_en,
    input  logic             is_signed,
    input  logic [31:0]      op_a,
    input  logic [31:0]      op_b,
    output logic [ACC_W-1:0] dot_sum
);

    localparam int unsigned NLANES = 32 / ELEM_W;
    localparam int unsigned PROD_W = 2 * ELEM_W;

    logic [PROD_W-1:0] prod_q [NLANES];

    // Low PROD_W bits of the extended product are exact for both signed and unsigned lanes.
    function automatic logic [PROD_W-1:0] lane_mul(input logic [ELEM_W-1:0] a,
                                                   input logic [ELEM_W-1:0] b,
                                                   input logic              sgn);
        logic [PROD_W-1:0] ae;
        logic [PROD_W-1:0] be;
        ae = {{ELEM_W{sgn & a[ELEM_W-1]}}, a};
        be = {{ELEM_W{sgn & b[ELEM_W-1]}}, b};
        return ae * be;
    endfunction

    function automatic logic [ACC_W-1:0] ext_prod(input logic [PROD_W-1:0] p,
                                                  input logic              sgn);
        return {{(ACC_W - PROD_W){sgn & p[PROD_W-1]}}, p};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NLANES; i++) begin
                prod_q[i] <= '0;
            end
        end else if (mult_en) begin
            for (int unsigned i = 0; i < NLANES; i++) begin
                prod_q[i] <= lane_mul(op_a[i*ELEM_W +: ELEM_W], op_b[i*ELEM_W +: ELEM_W],
                                      is_signed);
            end
        end
    end

    // ACC_W leaves headroom for every lane sum, so the reduction cannot wrap.
    always_comb begin
        dot_sum = '0;
        for (int unsigned i = 0; i < NLANES; i++) begin
            dot_sum = dot_sum + ext_prod(prod_q[i], is_signed);
        end
    end

endmodule

// File: rtl/riscv_simd_mac_unit.sv
// EX-stage packed-SIMD MAC unit: dot product, persistent accumulator with sticky
// overflow, optional 32-bit saturation, and the enable/ready/ex_ready handshake.
module riscv_simd_mac_unit
    import riscv_simd_mac_unit_pkg::*;
#(
    parameter int unsigned ELEM_W = 8,
    parameter int unsigned ACC_W  = 40,
    parameter bit          SAT_EN = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable_i,
    input  logic [MAC_OP_WIDTH-1:0] operator_i,
    input  logic [31:0]             operand_i1,
    input  logic [31:0]             operand_i2,
    input  logic                    ex_ready_i,
    output logic                    ready_o,
    output logic [31:0]             result_o,
    output logic                    active_o,
    output logic                    acc_ovf_o
);

    // Wide enough to sign-extend the accumulator and still see bit 31 overflow.
    localparam int unsigned EXT_W = (ACC_W > 32) ? ACC_W : 33;

    smac_state_e             state_q;
    logic [MAC_OP_WIDTH-1:0] op_q;
    logic [31:0]             opa_q;
    logic [31:0]             opb_q;
    logic [ACC_W-1:0]        acc_q;
    logic                    ovf_q;
    logic [31:0]             result_q;

    logic             accept;
    logic             start_dot;
    logic [ACC_W-1:0] dot_sum;
    logic [ACC_W-1:0] acc_sum;
    logic             add_ovf;

    function automatic logic [31:0] to_result(input logic [ACC_W-1:0] v);
        logic [EXT_W-1:0] w;
        logic             fits;
        w    = EXT_W'($signed(v));
        fits = (&w[EXT_W-1:31]) || !(|w[EXT_W-1:31]);
        if (SAT_EN && !fits) begin
            return w[EXT_W-1] ? 32'h8000_0000 : 32'h7fff_ffff;
        end
        return w[31:0];
    endfunction

    assign start_dot = smac_is_dot_acc(operator_i);
    assign accept    = (state_q == IDLE) && enable_i && (start_dot || smac_is_ctl(operator_i));

    assign acc_sum = acc_q + dot_sum;
    assign add_ovf = (acc_q[ACC_W-1] == dot_sum[ACC_W-1]) &&
                     (acc_sum[ACC_W-1] != acc_q[ACC_W-1]);

    riscv_simd_dot #(
        .ELEM_W (ELEM_W),
        .ACC_W  (ACC_W)
    ) u_dot (
        .clk       (clk),
        .rst_n     (rst_n),
        .mult_en   (state_q == MULT),
        .is_signed (smac_is_signed(op_q)),
        .op_a      (opa_q),
        .op_b      (opb_q),
        .dot_sum   (dot_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
            result_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q  <= operator_i;
                        opa_q <= operand_i1;
                        opb_q <= operand_i2;
                        if (start_dot) begin
                            state_q <= MULT;
                        end else begin
                            // CLR/RD need no datapath pass and complete on the accept edge.
                            state_q <= FINISH;
                            if (operator_i == SMAC_CLR) begin
                                acc_q    <= '0;
                                ovf_q    <= 1'b0;
                                result_q <= '0;
                            end else begin
                                result_q <= to_result(acc_q);
                            end
                        end
                    end
                end
                MULT: begin
                    state_q <= SUM;
                end
                SUM: begin
                    state_q <= FINISH;
                    if (smac_is_acc(op_q)) begin
                        acc_q    <= acc_sum;
                        ovf_q    <= ovf_q | add_ovf;
                        result_q <= to_result(acc_sum);
                    end else begin
                        result_q <= to_result(dot_sum);
                    end
                end
                FINISH: begin
                    if (ex_ready_i) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Ready drops combinationally in the accept cycle so the EX stage stalls at once.
    assign ready_o   = ((state_q == IDLE) && !accept) || (state_q == FINISH);
    assign active_o  = (state_q != IDLE);
    assign result_o  = result_q;
    assign acc_ovf_o = ovf_q;

endmodule

// File: tb/tb_riscv_simd_mac_unit.sv
// Drives three parameterisations of the SIMD MAC unit with one shared request stream and
// compares each against an arithmetic reference model of dot/accumulate/saturate rules.
module tb_riscv_simd_mac_unit;
    import riscv_simd_mac_unit_pkg::*;

    logic                    clk;
    logic                    rst_n;
    logic                    enable;
    logic [MAC_OP_WIDTH-1:0] op_in;
    logic [31:0]             opa;
    logic [31:0]             opb;
    logic                    ex_ready;
    logic [2:0]              rdy;
    logic [2:0]              act;
    logic [2:0]              ovf;
    logic [2:0][31:0]        res;

    int n_tests = 0;
    int n_fail  = 0;

    longint      acc_m [3];
    bit          ovf_m [3];
    logic [31:0] res_m [3];

    riscv_simd_mac_unit #(.ELEM_W(8), .ACC_W(40), .SAT_EN(1'b1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .enable_i(enable), .operator_i(op_in),
        .operand_i1(opa), .operand_i2(opb), .ex_ready_i(ex_ready),
        .ready_o(rdy[0]), .result_o(res[0]), .active_o(act[0]), .acc_ovf_o(ovf[0])
    );
    riscv_simd_mac_unit #(.ELEM_W(16), .ACC_W(34), .SAT_EN(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .enable_i(enable), .operator_i(op_in),
        .operand_i1(opa), .operand_i2(opb), .ex_ready_i(ex_ready),
        .ready_o(rdy[1]), .result_o(res[1]), .active_o(act[1]), .acc_ovf_o(ovf[1])
    );
    riscv_simd_mac_unit #(.ELEM_W(16), .ACC_W(34), .SAT_EN(1'b0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .enable_i(enable), .operator_i(op_in),
        .operand_i1(opa), .operand_i2(opb), .ex_ready_i(ex_ready),
        .ready_o(rdy[2]), .result_o(res[2]), .active_o(act[2]), .acc_ovf_o(ovf[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int ew_of(input int k);
        return (k == 0) ? 8 : 16;
    endfunction

    function automatic int accw_of(input int k);
        return (k == 0) ? 40 : 34;
    endfunction

    function automatic bit sat_of(input int k);
        return k != 2;
    endfunction

    function automatic longint dot_model(input int ew, input bit sgn,
                                         input logic [31:0] a, input logic [31:0] b);
        longint s, x, y, m;
        s = 0;
        m = (longint'(1) << ew) - 1;
        for (int i = 0; i < 32 / ew; i++) begin
            x = longint'(a >> (i * ew)) & m;
            y = longint'(b >> (i * ew)) & m;
            if (sgn && x > (m >>> 1)) x = x - (m + 1);
            if (sgn && y > (m >>> 1)) y = y - (m + 1);
            s = s + x * y;
        end
        return s;
    endfunction

    function automatic longint wrap(input longint v, input int w);
        longint p, m;
        p = longint'(1) << w;
        m = v & (p - 1);
        if (m >= (p >>> 1)) m = m - p;
        return m;
    endfunction

    function automatic logic [31:0] clamp32(input longint v, input bit sat);
        longint hi, lo;
        hi = (longint'(1) << 31) - 1;
        lo = -(longint'(1) << 31);
        if (sat && v > hi) return 32'h7fff_ffff;
        if (sat && v < lo) return 32'h8000_0000;
        return v[31:0];
    endfunction

    task automatic model_step(input logic [MAC_OP_WIDTH-1:0] op,
                              input logic [31:0] a, input logic [31:0] b);
        for (int k = 0; k < 3; k++) begin
            longint d, s, lim;
            d   = dot_model(ew_of(k), (op == SMAC_DOTS) || (op == SMAC_ACCS), a, b);
            lim = longint'(1) << (accw_of(k) - 1);
            case (op)
                SMAC_DOTU, SMAC_DOTS: res_m[k] = clamp32(d, sat_of(k));
                SMAC_ACCU, SMAC_ACCS: begin
                    s = acc_m[k] + d;
                    if (s >= lim || s < -lim) ovf_m[k] = 1'b1;
                    acc_m[k] = wrap(s, accw_of(k));
                    res_m[k] = clamp32(acc_m[k], sat_of(k));
                end
                SMAC_CLR: begin
                    acc_m[k] = 0;
                    ovf_m[k] = 1'b0;
                    res_m[k] = 32'h0;
                end
                SMAC_RD: res_m[k] = clamp32(acc_m[k], sat_of(k));
                default: ;
            endcase
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            acc_m[k] = 0;
            ovf_m[k] = 1'b0;
            res_m[k] = 32'h0;
        end
    endtask

    task automatic check_outputs(input string tag);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s_res%0d", tag, k), res[k], res_m[k]);
            check($sformatf("%s_ovf%0d", tag, k), 32'(ovf[k]), 32'(ovf_m[k]));
        end
    endtask

    // One request: count ready-low cycles, then hold FINISH for 'hold' extra cycles.
    task automatic run_op(input logic [MAC_OP_WIDTH-1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int hold);
        int lows;
        int exp_lows;
        bit accepted;
        accepted = (op >= SMAC_DOTU) && (op <= SMAC_RD);
        exp_lows = !accepted ? 0 : ((op == SMAC_CLR) || (op == SMAC_RD)) ? 1 : 3;
        @(negedge clk);
        enable   = 1'b1;
        op_in    = op;
        opa      = a;
        opb      = b;
        ex_ready = (hold == 0);
        #1;
        lows = 0;
        while (!rdy[0] && lows < 10) begin
            lows++;
            @(negedge clk);
            enable = 1'b0;
            op_in  = MAC_OP_WIDTH'($urandom);
            opa    = $urandom;
            opb    = $urandom;
            #1;
        end
        enable = 1'b0;
        check($sformatf("lat_op%0h", op), lows, exp_lows);
        model_step(op, a, b);
        check_outputs($sformatf("op%0h", op));
        if (accepted) begin
            for (int k = 0; k < 3; k++) check($sformatf("fin_act%0d", k), 32'(act[k]), 1);
            repeat (hold) begin
                @(negedge clk);
                #1;
                for (int k = 0; k < 3; k++) begin
                    check($sformatf("hold_res%0d", k), res[k], res_m[k]);
                    check($sformatf("hold_rdy%0d", k), 32'(rdy[k]), 1);
                end
            end
            ex_ready = 1'b1;
            @(negedge clk);
            #1;
            for (int k = 0; k < 3; k++) begin
                check($sformatf("idle_act%0d", k), 32'(act[k]), 0);
                check($sformatf("idle_res%0d", k), res[k], res_m[k]);
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        enable   = 1'b0;
        op_in    = '0;
        opa      = '0;
        opb      = '0;
        ex_ready = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_rdy%0d", k), 32'(rdy[k]), 1);
            check($sformatf("rst_act%0d", k), 32'(act[k]), 0);
        end
        check_outputs("rst");

        run_op(SMAC_DOTU, 32'h0102_0304, 32'h0506_0708, 0);
        check("dotu_70", res[0], 32'd70);
        run_op(SMAC_DOTS, 32'hffff_ffff, 32'h0101_0101, 0);
        check("dots_m4", res[0], 32'hffff_fffc);
        run_op(SMAC_DOTU, 32'hffff_ffff, 32'h0101_0101, 1);
        check("dotu_1020", res[0], 32'd1020);
        run_op(SMAC_DOTU, 32'hffff_ffff, 32'hffff_ffff, 0);
        check("dotu16_sat", res[1], 32'h7fff_ffff);
        check("dotu16_trunc", res[2], 32'hfffc_0002);

        run_op(SMAC_CLR, 32'h0, 32'h0, 0);
        run_op(SMAC_ACCS, 32'h0102_0304, 32'h0506_0708, 0);
        run_op(SMAC_ACCS, 32'h0102_0304, 32'h0506_0708, 5);
        check("acc_140", res[0], 32'd140);
        run_op(SMAC_ACCS, 32'h0102_0304, 32'h0506_0708, 0);
        run_op(SMAC_RD, 32'h0, 32'h0, 2);
        check("rd_210", res[0], 32'd210);

        run_op(SMAC_CLR, 32'h0, 32'h0, 0);
        for (int n = 0; n < 3; n++) run_op(SMAC_ACCS, 32'h8000_8000, 32'h8000_8000, 0);
        check("ovf_after3", 32'(ovf[1]), 0);
        run_op(SMAC_ACCS, 32'h8000_8000, 32'h8000_8000, 0);
        check("ovf_after4", 32'(ovf[1]), 1);
        run_op(SMAC_RD, 32'h0, 32'h0, 0);
        check("rd_neg_sat", res[1], 32'h8000_0000);
        run_op(SMAC_CLR, 32'h0, 32'h0, 0);
        check("clr_ovf", 32'(ovf[1]), 0);

        run_op(MAC_OP, 32'h1234_5678, 32'h9abc_def0, 0);
        run_op(WB23_OP, 32'h1, 32'h1, 0);

        for (int n = 0; n < 60; n++) begin
            logic [MAC_OP_WIDTH-1:0] op;
            logic [31:0]             a;
            logic [31:0]             b;
            int                      r;
            r  = $urandom_range(0, 19);
            op = (r < 16) ? MAC_OP_WIDTH'(4 + (r % 6)) : MAC_OP_WIDTH'($urandom_range(0, 15));
            r  = $urandom_range(0, 3);
            a  = (r == 0) ? 32'h8000_8000 : (r == 1) ? 32'hffff_ffff : $urandom;
            b  = (r == 0) ? 32'h8000_7fff : $urandom;
            run_op(op, a, b, $urandom_range(0, 2));
        end

        run_op(SMAC_CLR, 32'h0, 32'h0, 0);
        run_op(SMAC_ACCS, 32'h0102_0304, 32'h0506_0708, 0);
        check("pre_rst_70", res[0], 32'd70);
        @(negedge clk);
        enable   = 1'b1;
        op_in    = SMAC_ACCS;
        opa      = 32'h0102_0304;
        opb      = 32'h0506_0708;
        ex_ready = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b0;
        @(posedge clk);
        #1;
        check("sum_act", 32'(act[0]), 1);
        check("sum_rdy", 32'(rdy[0]), 0);
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("mid_rst_rdy%0d", k), 32'(rdy[k]), 1);
            check($sformatf("mid_rst_act%0d", k), 32'(act[k]), 0);
        end
        check_outputs("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        run_op(SMAC_RD, 32'h0, 32'h0, 0);
        check("rd_after_rst", res[0], 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
